// File: rtl/lb_soc_pkg.sv
// lb_soc_pkg: definitions shared by the PicoBlaze SoC reset-request
// peripheral and the logic around it.
//   - register address constants (port_id low bits)
//   - unlock key bytes
//   - request state machine encoding
//   - STATUS bit indices and the packed STATUS layout
package lb_soc_pkg;

  // Register map
  localparam logic [1:0] ADDR_KEY    = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_KICK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Two-byte unlock sequence: arm first, then fire
  localparam logic [7:0] KEY_ARM  = 8'hA5;
  localparam logic [7:0] KEY_FIRE = 8'h5A;

  // Request state machine
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2
  } req_state_t;

  // STATUS bit indices
  localparam int STAT_ARMED     = 0;
  localparam int STAT_PULSE     = 1;
  localparam int STAT_CAUSE_WDT = 2;
  localparam int STAT_CAUSE_SW  = 3;

  // STATUS register image. armed/pulse_active are a direct view of the
  // request state machine, so this struct doubles as its debug window.
  typedef struct packed {
    logic [3:0] rsvd;
    logic       cause_sw;
    logic       cause_wdt;
    logic       pulse_active;
    logic       armed;
  } status_t;

endpackage

// File: rtl/lb_down_counter.sv
// lb_down_counter: loadable down counter that parks at zero.
// Ports:
//   clk, resetb : clock, asynchronous active-low reset (count -> 0)
//   clr         : force count to 0 (highest priority)
//   load        : load load_val (beats en)
//   load_val    : value loaded when load is high
//   en          : decrement by one per cycle while count is non-zero
//   zero        : count == 0
module lb_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lb_reset_requester.sv
// lb_reset_requester: firmware-initiated system reset request.
// Firmware requests a reset either with the two-byte key A5 then 5A on
// KEY, or by letting the watchdog expire. The result is a registered,
// active-low, RST_LEN-cycle pulse on reset_req_b. Sticky cause flags
// live on resetb (button/power-on only), so they survive the system
// reset this block causes.
// Ports:
//   clk          : system clock
//   resetb       : asynchronous active-low reset (button/power-on)
//   cs           : block select
//   write_strobe : PicoBlaze write strobe (one cycle)
//   addr         : register select (0 KEY, 1 CTRL, 2 KICK, 3 STATUS)
//   data_in      : write data
//   data_out     : STATUS when cs && addr==3, else 0 (combinational)
//   reset_req_b  : active-low reset request, registered
// Bus protocol: a write is accepted in any cycle where cs & write_strobe
// is high, with addr/data_in valid in that same cycle. There is no
// back-pressure; the block always accepts. Reads are combinational.
module lb_reset_requester
  import lb_soc_pkg::*;
#(
  parameter int RST_LEN    = 16,
  parameter int ARM_WINDOW = 256,
  parameter int WDT_W      = 24
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       cs,
  input  logic       write_strobe,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       reset_req_b
);

  localparam int WIN_W = $clog2(ARM_WINDOW + 1);
  localparam int LEN_W = $clog2(RST_LEN + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(ARM_WINDOW - 1);
  localparam logic [LEN_W-1:0] LEN_LOAD = LEN_W'(RST_LEN - 1);
  localparam logic [WDT_W-1:0] WDT_LOAD = {WDT_W{1'b1}};

  req_state_t state, state_next;

  logic    wr;
  logic    in_pulse;
  logic    key_wr, ctrl_wr, kick_wr, status_wr;
  logic    key_fire, wdt_expire, enter_pulse;
  logic    wdt_en, wdt_load, wdt_stop, wdt_clr, wdt_zero;
  logic    win_load, win_en, win_zero;
  logic    len_load, len_en, len_zero;
  logic    armed, pulse_active;
  logic    cause_sw, cause_wdt;
  status_t status;

  // ---------------------------------------------------------------
  // Write decode. While a pulse is running, only STATUS clears are
  // honoured.
  // ---------------------------------------------------------------
  assign wr        = cs & write_strobe;
  assign in_pulse  = (state == ST_PULSE);
  assign key_wr    = wr & (addr == ADDR_KEY)  & ~in_pulse;
  assign ctrl_wr   = wr & (addr == ADDR_CTRL) & ~in_pulse;
  assign kick_wr   = wr & (addr == ADDR_KICK) & ~in_pulse;
  assign status_wr = wr & (addr == ADDR_STATUS);

  // ---------------------------------------------------------------
  // Request events
  // ---------------------------------------------------------------
  assign key_fire = (state == ST_ARMED) & key_wr & (data_in == KEY_FIRE);

  // A kick or a disable landing in the expiry cycle takes precedence.
  assign wdt_stop   = ctrl_wr & ~data_in[0];
  assign wdt_expire = wdt_en & wdt_zero & ~in_pulse & ~kick_wr & ~wdt_stop;

  assign enter_pulse = key_fire | wdt_expire;

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enter_pulse) begin
          state_next = ST_PULSE;
        end else if (key_wr && (data_in == KEY_ARM)) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (enter_pulse) begin
          state_next = ST_PULSE;
        end else if (key_wr) begin
          state_next = ST_IDLE;  // wrong second byte
        end else if (win_zero) begin
          state_next = ST_IDLE;  // window closed
        end
      end
      ST_PULSE: begin
        if (len_zero) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs (counter controls and STATUS state bits)
  // ---------------------------------------------------------------
  always_comb begin
    armed        = 1'b0;
    pulse_active = 1'b0;
    win_load     = 1'b0;
    win_en       = 1'b0;
    len_load     = enter_pulse;
    len_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        win_load = key_wr & (data_in == KEY_ARM) & ~enter_pulse;
      end
      ST_ARMED: begin
        armed  = 1'b1;
        win_en = 1'b1;
      end
      ST_PULSE: begin
        pulse_active = 1'b1;
        len_en       = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------
  lb_down_counter #(.W(WIN_W)) u_win_cnt (
    .clk      (clk),
    .resetb   (resetb),
    .clr      (1'b0),
    .load     (win_load),
    .load_val (WIN_LOAD),
    .en       (win_en),
    .zero     (win_zero)
  );

  lb_down_counter #(.W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .resetb   (resetb),
    .clr      (1'b0),
    .load     (len_load),
    .load_val (LEN_LOAD),
    .en       (len_en),
    .zero     (len_zero)
  );

  // Reload only on an enable edge (0->1) or a kick while enabled.
  assign wdt_load = (ctrl_wr & data_in[0] & ~wdt_en) | (kick_wr & wdt_en);
  // Entering a pulse drops the watchdog; firmware re-arms after reset.
  assign wdt_clr  = wdt_stop | enter_pulse;

  lb_down_counter #(.W(WDT_W)) u_wdt_cnt (
    .clk      (clk),
    .resetb   (resetb),
    .clr      (wdt_clr),
    .load     (wdt_load),
    .load_val (WDT_LOAD),
    .en       (wdt_en & ~in_pulse),
    .zero     (wdt_zero)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wdt_en <= 1'b0;
    end else if (enter_pulse) begin
      wdt_en <= 1'b0;
    end else if (ctrl_wr) begin
      wdt_en <= data_in[0];
    end
  end

  // ---------------------------------------------------------------
  // Sticky cause flags: write-1-to-clear, a same-cycle set wins.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cause_sw  <= 1'b0;
      cause_wdt <= 1'b0;
    end else begin
      cause_sw  <= (cause_sw  & ~(status_wr & data_in[STAT_CAUSE_SW]))  | key_fire;
      cause_wdt <= (cause_wdt & ~(status_wr & data_in[STAT_CAUSE_WDT])) | wdt_expire;
    end
  end

  // ---------------------------------------------------------------
  // Request output: registered copy of "next state is PULSE", so it
  // falls on the same edge that enters PULSE and lasts RST_LEN cycles.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      reset_req_b <= 1'b1;
    end else begin
      reset_req_b <= (state_next != ST_PULSE);
    end
  end

  // ---------------------------------------------------------------
  // STATUS read
  // ---------------------------------------------------------------
  always_comb begin
    status              = '0;
    status.armed        = armed;
    status.pulse_active = pulse_active;
    status.cause_wdt    = cause_wdt;
    status.cause_sw     = cause_sw;
  end

  assign data_out = (cs && (addr == ADDR_STATUS)) ? status : 8'h00;

endmodule

// File: tb/tb_lb_reset_requester.sv
module tb_lb_reset_requester;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       cs = 1'b0;
  logic       write_strobe = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       reset_req_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lb_reset_requester #(
    .RST_LEN    (16),
    .ARM_WINDOW (256),
    .WDT_W      (4)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .cs           (cs),
    .write_strobe (write_strobe),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .reset_req_b  (reset_req_b)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; write_strobe = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; write_strobe = 1'b0; addr = 2'd0; data_in = 8'h00;
  endtask

  task automatic check_status(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    cs = 1'b1; addr = 2'd3;
    #1;
    v = data_out;
    cs = 1'b0; addr = 2'd0;
    check(tag, v, exp);
  endtask

  // Counts low samples of reset_req_b over 40 cycles from now.
  task automatic measure_low(output int n);
    n = 0;
    repeat (40) begin
      if (reset_req_b === 1'b0) n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    // ---- reset ----
    tick(2);
    check("rst_req_b", reset_req_b, 1);
    check_status("rst_status", 8'h00);
    check("rst_data_out_nocs", data_out, 8'h00);
    resetb = 1'b1;
    tick(2);

    // ---- key sequence, 3 cycles apart ----
    wr(2'd0, 8'hA5);
    check_status("key_armed", 8'h01);
    tick(2);
    wr(2'd0, 8'h5A);
    check("key_req_low", reset_req_b, 0);
    check_status("key_status_pulse", 8'h0A);
    measure_low(n);
    check("key_pulse_len", n, 16);
    check_status("key_status_after", 8'h08);
    wr(2'd3, 8'h08);
    check_status("key_clear", 8'h00);

    // ---- window expiry ----
    wr(2'd0, 8'hA5);
    check_status("win_armed", 8'h01);
    tick(260);
    check_status("win_closed", 8'h00);
    wr(2'd0, 8'h5A);
    measure_low(n);
    check("win_no_pulse", n, 0);
    check_status("win_status", 8'h00);

    // ---- wrong second byte, then lone fire byte ----
    wr(2'd0, 8'hA5);
    wr(2'd0, 8'h11);
    check_status("bad_key_idle", 8'h00);
    wr(2'd0, 8'h5A);
    measure_low(n);
    check("bad_key_no_pulse", n, 0);
    check_status("bad_key_status", 8'h00);

    // ---- watchdog expiry ----
    wr(2'd1, 8'h01);
    n = 0;
    while (reset_req_b === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wdt_latency", n, 16);
    check_status("wdt_status_pulse", 8'h06);
    measure_low(n);
    check("wdt_pulse_len", n, 16);
    check_status("wdt_status_after", 8'h04);
    measure_low(n);
    check("wdt_en_cleared", n, 0);
    wr(2'd3, 8'h04);
    check_status("wdt_clear", 8'h00);

    // ---- periodic kicks ----
    wr(2'd1, 8'h01);
    n = 0;
    repeat (20) begin
      repeat (9) begin
        @(negedge clk);
        if (reset_req_b === 1'b0) n++;
      end
      wr(2'd2, 8'h00);
      if (reset_req_b === 1'b0) n++;
    end
    check("kick_no_pulse", n, 0);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h00);  // kick while disabled
    measure_low(n);
    check("kick_disabled_no_pulse", n, 0);
    check_status("kick_status", 8'h00);

    // ---- kick in the expiry cycle wins ----
    wr(2'd1, 8'h01);
    tick(15);
    wr(2'd2, 8'h00);
    check("kick_win_req", reset_req_b, 1);
    wr(2'd1, 8'h00);
    measure_low(n);
    check("kick_win_no_pulse", n, 0);
    check_status("kick_win_status", 8'h00);

    // ---- expiry coincident with key completion ----
    wr(2'd1, 8'h01);
    wr(2'd0, 8'hA5);
    tick(14);
    wr(2'd0, 8'h5A);
    check("both_req_low", reset_req_b, 0);
    check_status("both_status_pulse", 8'h0E);
    measure_low(n);
    check("both_pulse_len", n, 16);
    check_status("both_status", 8'h0C);
    wr(2'd3, 8'h0C);
    check_status("both_clear", 8'h00);

    // ---- resetb mid-pulse ----
    wr(2'd0, 8'hA5);
    wr(2'd0, 8'h5A);
    tick(5);
    check("mid_req_low", reset_req_b, 0);
    #2 resetb = 1'b0;
    #1;
    check("mid_req_released", reset_req_b, 1);
    check_status("mid_status_reset", 8'h00);
    @(negedge clk);
    resetb = 1'b1;
    measure_low(n);
    check("mid_no_further_pulse", n, 0);
    check_status("mid_status_after", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
